// File: rtl/vga_pkg.sv
// Shared pattern-mode encodings and default colour depth for the animated VGA pattern generator.
package vga_pkg;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_CHECK = 2'd1;
  localparam logic [1:0] MODE_DIAG  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  localparam int DEFAULT_COLOR_BITS = 2;

endpackage

// File: rtl/vga_frame_timer.sv
// Per-frame state: vsync edge detect, frame counter, horizontal scroll accumulator and mode latch.
module vga_frame_timer
  import vga_pkg::*;
#(
  parameter int   COORD_W   = 10,
  parameter int   FRAME_W   = 8,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic [1:0]         mode,
  input  logic [2:0]         speed,
  input  logic               pause,
  output logic               frame_tick,
  output logic [FRAME_W-1:0] frame_count,
  output logic [COORD_W-1:0] scroll,
  output logic [1:0]         mode_q
);

  logic               vs_reg;
  logic [FRAME_W-1:0] frame_count_reg;
  logic [COORD_W-1:0] scroll_reg;
  logic [1:0]         mode_reg;

  // One tick on the edge into the asserted vsync level, whatever the polarity.
  assign frame_tick = (vsync == VSYNC_POL) && (vs_reg != VSYNC_POL);

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_reg          <= ~VSYNC_POL;
      frame_count_reg <= '0;
      scroll_reg      <= '0;
      mode_reg        <= MODE_BARS;
    end else begin
      vs_reg <= vsync;
      if (frame_tick) begin
        // The mode is latched even while paused so a paused display can still switch pattern.
        mode_reg <= mode;
        if (!pause) begin
          frame_count_reg <= frame_count_reg + 1'b1;
          scroll_reg      <= scroll_reg + COORD_W'(speed);
        end
      end
    end
  end

  assign frame_count = frame_count_reg;
  assign scroll      = scroll_reg;
  assign mode_q      = mode_reg;

endmodule

// File: rtl/vga_anim_pattern_gen.sv
// Animated VGA pattern generator: frame-latched mode, scrolling pattern mux and one-clock
// registered RGB output stage.
module vga_anim_pattern_gen
  import vga_pkg::*;
#(
  parameter int   COLOR_BITS = DEFAULT_COLOR_BITS,
  parameter int   COORD_W    = 10,
  parameter int   FRAME_W    = 8,
  parameter logic VSYNC_POL  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_W-1:0]    pix_x,
  input  logic [COORD_W-1:0]    pix_y,
  input  logic                  video_active,
  input  logic                  vsync,
  input  logic [1:0]            mode,
  input  logic [2:0]            speed,
  input  logic                  pause,
  output logic [COLOR_BITS-1:0] R,
  output logic [COLOR_BITS-1:0] G,
  output logic [COLOR_BITS-1:0] B,
  output logic [FRAME_W-1:0]    frame_count
);

  localparam int CB = COLOR_BITS;

  logic               frame_tick;
  logic [COORD_W-1:0] scroll;
  logic [1:0]         mode_q;
  logic [FRAME_W-1:0] frame_count_int;

  vga_frame_timer #(
    .COORD_W   (COORD_W),
    .FRAME_W   (FRAME_W),
    .VSYNC_POL (VSYNC_POL)
  ) u_frame_timer (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .mode        (mode),
    .speed       (speed),
    .pause       (pause),
    .frame_tick  (frame_tick),
    .frame_count (frame_count_int),
    .scroll      (scroll),
    .mode_q      (mode_q)
  );

  logic [COORD_W-1:0]  mx;
  logic [FRAME_W+1:0]  fc_x4;
  logic [COORD_W-1:0]  diag_sum;
  logic                check_bit;
  logic [CB-1:0]       pat_r, pat_g, pat_b;

  assign mx        = pix_x + scroll;
  assign fc_x4     = {frame_count_int, 2'b00};
  assign diag_sum  = mx + pix_y + COORD_W'(fc_x4);
  assign check_bit = mx[4] ^ pix_y[4];

  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (mode_q)
      MODE_BARS: begin
        pat_r = mx[5+:CB];
        pat_g = mx[6+:CB];
        pat_b = mx[7+:CB];
      end
      MODE_CHECK: begin
        pat_r = {CB{check_bit}};
        pat_g = {CB{check_bit}};
        pat_b = {CB{check_bit}};
      end
      MODE_DIAG: begin
        pat_r = diag_sum[8-:CB];
        pat_g = diag_sum[7-:CB];
        pat_b = diag_sum[6-:CB];
      end
      default: begin
        pat_r = frame_count_int[FRAME_W-1-:CB];
        pat_g = frame_count_int[FRAME_W-1-:CB];
        pat_b = frame_count_int[FRAME_W-1-:CB];
      end
    endcase
  end

  logic [CB-1:0] r_reg, g_reg, b_reg;

  // Blanking is applied at the register so RGB is zero outside the visible area.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg <= '0;
      g_reg <= '0;
      b_reg <= '0;
    end else if (video_active) begin
      r_reg <= pat_r;
      g_reg <= pat_g;
      b_reg <= pat_b;
    end else begin
      r_reg <= '0;
      g_reg <= '0;
      b_reg <= '0;
    end
  end

  assign R           = r_reg;
  assign G           = g_reg;
  assign B           = b_reg;
  assign frame_count = frame_count_int;

  // Some bits only feed wider colour depths; collected here so they are not reported unused.
  logic unused_bits;
  assign unused_bits = ^{frame_tick, mx, fc_x4, diag_sum};

endmodule
